// File: rtl/div_pkg.sv
// Shared types for the restoring divider: FSM state encoding.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/divide_if.sv
// Operand/result handshake bundle for the divider; the divider is the slave.
interface divide_if #(
   parameter int WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [2*WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]     divisor;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]     remainder;
   logic                 err;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, err
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, err
   );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in one dividend bit,
// conditionally subtract the divisor and emit the quotient bit.
module div_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;

   // rem_in[WIDTH] is the bit shifted out of the top; if set, the shifted
   // value certainly exceeds the divisor and the modular subtract is exact.
   always_comb begin
      shifted = {rem_in[WIDTH-1:0], bit_in};
      q_bit   = rem_in[WIDTH] | (shifted >= {1'b0, divisor});
      rem_out = q_bit ? (shifted - {1'b0, divisor}) : shifted;
   end

endmodule

// File: rtl/divide.sv
// Sequential unsigned divider, 2*WIDTH / WIDTH bits, one restoring step per cycle.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for an operation
//   BUSY  | running WIDTH iterations through the shared div_step
//   DONE  | out_valid=1, result held until out_ready
module divide
   import div_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic     clk,
   input  logic     rst,
   divide_if.slave  bus
);

   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   div_state_t        state_q, state_d;
   logic [WIDTH:0]    rem_q;
   logic [WIDTH-1:0]  dvd_q;
   logic [WIDTH-1:0]  dvs_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              err_q;

   logic              accept;
   logic              step_en;
   logic              op_err;
   logic [WIDTH:0]    step_rem;
   logic              step_q;

   // Quotient must fit in WIDTH bits: the upper dividend half has to be below the divisor.
   assign op_err = (bus.divisor == '0) || (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_q),
      .bit_in  (dvd_q[WIDTH-1]),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      accept        = 1'b0;
      step_en       = 1'b0;
      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               accept  = 1'b1;
               state_d = op_err ? DONE : BUSY;
            end
         end
         BUSY: begin
            step_en = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // dvd_q starts as the low dividend half and fills with quotient bits from the bottom.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q <= '0;
         dvd_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (accept) begin
         dvs_q <= bus.divisor;
         cnt_q <= '0;
         err_q <= op_err;
         if (op_err) begin
            rem_q <= '0;
            dvd_q <= '1;
         end else begin
            rem_q <= {1'b0, bus.dividend[2*WIDTH-1:WIDTH]};
            dvd_q <= bus.dividend[WIDTH-1:0];
         end
      end else if (step_en) begin
         rem_q <= step_rem;
         dvd_q <= {dvd_q[WIDTH-2:0], step_q};
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign bus.quotient  = dvd_q;
   assign bus.remainder = rem_q[WIDTH-1:0];
   assign bus.err       = err_q;

endmodule

// File: doc/divide.md
DIVIDE -- requirements
Module: divide

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the divisor, quotient and remainder width; the dividend is 2*WIDTH bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port in_valid, input, 1 bit: dividend/divisor are valid.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block can accept an operation.
REQ-006 The module SHALL have port dividend, input, 2*WIDTH bits: unsigned dividend.
REQ-007 The module SHALL have port divisor, input, WIDTH bits: unsigned divisor.
REQ-008 The module SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-009 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The module SHALL have port quotient, output, WIDTH bits.
REQ-011 The module SHALL have port remainder, output, WIDTH bits.
REQ-012 The module SHALL have port err, output, 1 bit: divide-by-zero or quotient overflow.

Function
REQ-013 The module SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 Accept: on an edge where in_valid && in_ready, the block SHALL register dividend and divisor and clear the iteration counter; later input changes SHALL be ignored.
REQ-016 Error check at accept: if divisor == 0 or dividend[2*WIDTH-1:WIDTH] >= divisor, the block SHALL go IDLE->DONE with err=1, quotient all ones and remainder 0 (out_valid 1 cycle after the accept edge).
REQ-017 Otherwise the block SHALL go IDLE->BUSY and perform WIDTH radix-2 restoring iterations, one per cycle, with the partial remainder held WIDTH+1 bits wide.
REQ-018 Each iteration SHALL shift {partial remainder, dividend low} left by 1; if the shifted remainder >= divisor, it SHALL subtract the divisor and shift in quotient bit 1, else shift in 0.
REQ-019 After the WIDTH-th iteration the block SHALL go BUSY->DONE with err=0, so out_valid asserts exactly WIDTH+1 cycles after the accept edge.
REQ-020 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor when err=0.
REQ-021 In DONE, quotient, remainder and err SHALL hold stable until an edge with out_ready=1; that edge SHALL return the FSM to IDLE.
REQ-022 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE (no back-to-back accept in the DONE-exit cycle).
REQ-023 If in_valid is asserted while in_ready=0, the operation SHALL NOT be accepted and the source SHALL hold it until in_ready=1.

Reset
REQ-024 On rst=1 at a clock edge, the FSM SHALL go to IDLE, the counter and all datapath registers SHALL clear to 0, and out_valid=0, quotient=0, remainder=0, err=0 and in_ready=1 from the next cycle.
REQ-025 Reset SHALL take priority over any in-flight BUSY or DONE operation and over a simultaneous in_valid; the aborted result SHALL never appear on the outputs.

Structure
REQ-026 A shared package div_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE).
REQ-027 The iteration-count width, $clog2(WIDTH+1), SHALL be a localparam in the module.
REQ-028 One combinational sub-module div_step SHALL implement a single restoring iteration (inputs: partial remainder, next dividend bit, divisor; outputs: new remainder, quotient bit); divide SHALL instantiate it once and reuse it across cycles.

Verification
REQ-029 Basic divide (WIDTH=16): dividend=1000, divisor=7 -> quotient=142, remainder=6, err=0, out_valid exactly 17 cycles after the accept edge.
REQ-030 Full-range divide: dividend=0xFFFE0001, divisor=0xFFFF -> quotient=0xFFFF, remainder=0, err=0.
REQ-031 Error cases: divisor=0, dividend=5 -> err=1, quotient=0xFFFF, remainder=0, 1 cycle after accept; dividend=0x00010000, divisor=1 -> err=1 by overflow.
REQ-032 Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; raise out_ready -> IDLE next cycle, and a new accept is possible only one cycle after that.
REQ-033 Reset mid-operation: assert rst 5 cycles into BUSY -> out_valid stays 0, in_ready=1 next cycle; a following 100/10 operation -> quotient=10, remainder=0.
REQ-034 Random self-check: 10k random operands with random valid/ready gaps, checked against REQ-020 or the REQ-016 error rule.
